// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multiport register file
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

endpackage

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - read/write port bundle between decode/writeback and the register file
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = RF_WIDTH,
  parameter int  DEPTH    = RF_DEPTH,
  parameter int  NUM_READ = 2,
  localparam int ADDR_W   = $clog2(DEPTH)
);

  logic [NUM_READ*ADDR_W-1:0] rs_address;
  logic [NUM_READ*WIDTH-1:0]  rs;
  logic                       write_enable;
  logic [ADDR_W-1:0]          write_address;
  logic [WIDTH-1:0]           write_data;
  logic                       ready;

  // master: decode/writeback side driving addresses and write data
  modport master (
    output rs_address, write_enable, write_address, write_data,
    input  rs, ready
  );

  // slave: the register file itself
  modport slave (
    input  rs_address, write_enable, write_address, write_data,
    output rs, ready
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset sequencer that zeroes one entry per cycle before raising ready
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int  DEPTH  = RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              ready
);

  regfile_state_e    state;
  logic [ADDR_W-1:0] clear_cnt;

  // Walk clear_cnt across the array once after every reset, then park in RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      clear_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Zeroing writes only happen on non-reset edges while clearing
  assign clear_we   = (state == CLEAR) && !reset;
  assign clear_addr = clear_cnt;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport decode-stage register file with clear sequencer; optional REGFILE_BYPASS_EN forwarding
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = RF_WIDTH,
  parameter int  DEPTH    = RF_DEPTH,
  parameter int  NUM_READ = 2,
  parameter int  ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  regfile_multiport_if.slave  bus
);

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              ready_q;
  logic              wb_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] ra [NUM_READ];
  logic [NUM_READ*WIDTH-1:0] rs_all;

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clock      (clock),
    .reset      (reset),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .ready      (ready_q)
  );

  // Writeback is accepted only in RUN and never lands on the hardwired-zero entry
  assign wb_en = ready_q && bus.write_enable &&
                 !((ZERO_REG != 0) && (bus.write_address == '0));

  // The clear sequencer owns the write port until ready; the two never overlap
  assign mem_we    = clear_we || wb_en;
  assign mem_addr  = clear_we ? clear_addr : bus.write_address;
  assign mem_wdata = clear_we ? '0 : bus.write_data;

  // Single synchronous write port into the array
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_ra
    assign ra[i] = bus.rs_address[i*ADDR_W +: ADDR_W];
  end

  // Combinational read ports: masked before ready and on the zero entry
  always_comb begin
    rs_all = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (!ready_q || ((ZERO_REG != 0) && (ra[i] == '0))) begin
        rs_all[i*WIDTH +: WIDTH] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wb_en && (bus.write_address == ra[i])) begin
        rs_all[i*WIDTH +: WIDTH] = bus.write_data;
`endif
      end else begin
        rs_all[i*WIDTH +: WIDTH] = mem[ra[i]];
      end
    end
  end

  assign bus.rs    = rs_all;
  assign bus.ready = ready_q;

endmodule
